// File: rtl/cache_pkg.sv
// Shared widths, FSM states and address field helpers for the cache fill path.
// Option: CACHE_FILL_CRITICAL_WORD_FIRST_EN rotates fill order to the miss word.
package cache_pkg;

  localparam int ADDR_W   = 16;
  localparam int INDEX_W  = 7;
  localparam int TAG_W    = 5;
  localparam int OFFSET_W = 4;
  localparam int WORDS    = 8;
  localparam int MEM_LAT  = 4;
  localparam int CNT_W    = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_t;

  function automatic logic [TAG_W-1:0] get_tag(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(
    input logic [ADDR_W-1:0] a
  );
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [CNT_W-1:0] get_word(
    input logic [ADDR_W-1:0] a
  );
    return a[OFFSET_W-1:1];
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear, enable and terminal-count flag.
// Option: none (CACHE_FILL_CRITICAL_WORD_FIRST_EN is handled by the top).
module fill_counter #(
  parameter int W   = 3,
  parameter int MAX = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: 8 pipelined word reads, data steering, tag update.
// Option: CACHE_FILL_CRITICAL_WORD_FIRST_EN adds crit_word_valid, wrapped order.
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               miss_detected,
  input  logic [ADDR_W-1:0]  miss_address,
  input  logic               memory_data_valid,
  input  logic [15:0]        memory_data,
  output logic               fsm_busy,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  memory_address,
  output logic [INDEX_W-1:0] set_index,
  output logic [CNT_W-1:0]   word_sel,
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  output logic               crit_word_valid,
`endif
  output logic               write_data_array,
  output logic               write_tag_array
);

  fill_state_t state, nstate;

  logic [ADDR_W-1:0] addr_q;
  logic              req_done;
  logic [CNT_W-1:0]  req_cnt, rcv_cnt;
  logic              req_tc, rcv_tc;
  logic              issue_en, rcv_en, cnt_clr;
  logic [CNT_W-1:0]  base, req_word, rcv_word;

  // memory_data goes straight to the data array; only the strobes live here
  logic unused_bits;
  assign unused_bits = ^{memory_data, addr_q[OFFSET_W-1:0]};

  assign cnt_clr  = (state != FILL);
  assign issue_en = (state == FILL) && !req_done;
  assign rcv_en   = (state == FILL) && memory_data_valid;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign base = get_word(addr_q);
`else
  assign base = '0;
`endif

  assign req_word = base + req_cnt;
  assign rcv_word = base + rcv_cnt;

  fill_counter #(.W(CNT_W), .MAX(WORDS-1)) u_req_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (issue_en),
    .cnt   (req_cnt),
    .tc    (req_tc)
  );

  fill_counter #(.W(CNT_W), .MAX(WORDS-1)) u_rcv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (rcv_en),
    .cnt   (rcv_cnt),
    .tc    (rcv_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      req_done <= 1'b0;
    end else begin
      state <= nstate;
      if (state == IDLE && miss_detected) begin
        addr_q <= miss_address;
      end
      // the issue counter wraps to 0; this flag stops a second pass
      if (cnt_clr) begin
        req_done <= 1'b0;
      end else if (issue_en && req_tc) begin
        req_done <= 1'b1;
      end
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (miss_detected) nstate = FILL;
      FILL:    if (rcv_en && rcv_tc) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    fsm_busy         = (state != IDLE);
    mem_req          = issue_en;
    memory_address   = '0;
    if (issue_en) begin
      memory_address = {addr_q[ADDR_W-1:OFFSET_W], req_word, 1'b0};
    end
    set_index        = get_index(addr_q);
    word_sel         = rcv_word;
    write_data_array = rcv_en;
    write_tag_array  = (state == DONE);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    crit_word_valid  = rcv_en && (rcv_cnt == '0);
`endif
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomised bench: pipelined memory model plus fill-order reference.
// Option: CACHE_FILL_CRITICAL_WORD_FIRST_EN enables crit-word checks.
module tb_cache_fill_fsm;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_req;
  logic [15:0] memory_address;
  logic [6:0]  set_index;
  logic [2:0]  word_sel;
  logic        write_data_array;
  logic        write_tag_array;
  logic        crit_word_valid;

  int checks = 0;
  int errors = 0;
  int t;

  int          due_q[$];
  logic [15:0] dat_q[$];

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_req           (mem_req),
    .memory_address    (memory_address),
    .set_index         (set_index),
    .word_sel          (word_sel),
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    .crit_word_valid   (crit_word_valid),
`endif
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array)
  );

`ifndef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign crit_word_valid = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, fsm_busy, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_addr"}, memory_address, 0);
    chk({tag, "_wr"}, write_data_array, 0);
    chk({tag, "_tag"}, write_tag_array, 0);
  endtask

  task automatic drive_mem(input int gap);
    if (due_q.size() > 0 && due_q[0] <= t &&
        $urandom_range(99) >= gap) begin
      memory_data_valid = 1'b1;
      memory_data       = dat_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
    end
  endtask

  task automatic run_fill(input logic [15:0] a, input int gap,
                          input bit hold, input int abort_at);
    int nreq = 0, nrcv = 0, ntag = 0, nbusy = 0;
    bit aborted = 0;
    logic [2:0] sw = 3'd0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    sw = a[3:1];
`endif
    due_q.delete();
    dat_q.delete();
    t = 0;
    @(posedge clk); #1;
    miss_detected     = 1'b1;
    miss_address      = a;
    memory_data_valid = 1'b0;
    @(negedge clk);
    chk("idle_before", fsm_busy, 0);
    for (t = 1; t < 80; t++) begin
      @(posedge clk); #1;
      miss_detected = hold && (ntag == 0);
      miss_address  = hold ? 16'($urandom) : a;
      drive_mem(gap);
      @(negedge clk);
      if (!fsm_busy) break;
      nbusy++;
      chk("set_index", set_index, a[10:4]);
      chk("req_slot", mem_req, nbusy <= 8);
      chk("wr_vs_valid", write_data_array, memory_data_valid);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      chk("crit", crit_word_valid, write_data_array && nrcv == 0);
`endif
      if (mem_req) begin
        chk("req_addr", memory_address,
            {a[15:4], 3'(sw + nreq), 1'b0});
        due_q.push_back(t + LAT);
        dat_q.push_back(memory_address ^ 16'h5A5A);
        nreq++;
      end
      if (write_data_array) begin
        chk("word_sel", word_sel, 3'(sw + nrcv));
        nrcv++;
      end
      if (write_tag_array) begin
        ntag++;
        chk("tag_after_last", nrcv, 8);
      end
      if (abort_at > 0 && nrcv == abort_at) begin
        aborted = 1;
        break;
      end
    end
    if (aborted) begin
      miss_detected = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_quiet("async_rst");
      chk("rst_sel", word_sel, 0);
      chk("rst_idx", set_index, 0);
      @(posedge clk); #1;
      chk_quiet("in_rst");
      @(negedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
        t++;
        @(posedge clk); #1;
        drive_mem(0);
        @(negedge clk);
        chk_quiet("late_valid");
      end
      memory_data_valid = 1'b0;
    end else begin
      chk("busy_end", fsm_busy, 0);
      chk("n_req", nreq, 8);
      chk("n_rcv", nrcv, 8);
      chk("n_tag", ntag, 1);
      if (gap == 0) chk("busy_cycles", nbusy, 13);
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
    #3;
    chk_quiet("reset");
    chk("reset_idx", set_index, 0);
    chk("reset_sel", word_sel, 0);
    @(negedge clk); #1 rst_n = 1'b1;

    run_fill(16'h1A36, 0, 0, 0);
    run_fill(16'h1A36, 50, 0, 0);
    run_fill(16'h2222, 0, 1, 0);
    run_fill(16'hFFF0, 0, 0, 0);
    run_fill(16'h004A, 0, 0, 0);
    run_fill(16'h3C1E, 30, 0, 3);
    run_fill(16'h3C1E, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      run_fill(16'($urandom), $urandom_range(60),
               1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Cache miss-fill controller for the 128-set direct-mapped caches. On a miss it issues 8 word reads to the pipelined 4-cycle main memory and steers each returned word into the data array. It drives the 7-bit set index into the downstream 7-to-128 one-hot set decoder, plus word-select and write strobes. At the end of the fill it updates the tag array.

Parameters:
ADDR_W, 16, byte-address width
INDEX_W, 7, set-index width (128 sets; feeds the 7-to-128 decoder)
WORDS, 8, 16-bit words per block (16-byte block)
MEM_LAT, 4, cycles from memory request to memory_data_valid

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
miss_detected  in  1  miss on the current access; sampled in IDLE only
miss_address  in  16  byte address of the missing access
memory_data_valid  in  1  memory_data holds the word for the oldest outstanding request
memory_data  in  16  returned word
fsm_busy  out  1  fill in progress; pipeline stalls
mem_req  out  1  read request to memory this cycle
memory_address  out  16  word-aligned request address
set_index  out  7  miss_address[10:4], held for the whole fill; to the decoder's encoded input
word_sel  out  3  target word within the block for write_data_array
write_data_array  out  1  write memory_data into data[set_index][word_sel]
write_tag_array  out  1  one-cycle strobe to write the tag (miss_address[15:11]) and set valid

Behaviour:
- Address split: offset [3:0], index [10:4], tag [15:11]. The miss address is captured on entry to FILL and held until IDLE.
- Reset (async, rst_n=0): state=IDLE, all counters 0, fsm_busy=0, mem_req=0, write_data_array=0, write_tag_array=0, memory_address=0, set_index=0, word_sel=0.
- States: IDLE, FILL, DONE.
- IDLE to FILL: taken when miss_detected=1. The captured address is registered. The first request appears on the cycle after detection.
- FILL, request side:
  - Issue counter req_cnt runs 0..7.
  - mem_req=1 and memory_address={tag,index,req_cnt,1'b0}, one request per cycle for 8 consecutive cycles.
  - After the 8th request, mem_req=0.
- FILL, return side:
  - Receive counter rcv_cnt runs 0..7.
  - Each memory_data_valid cycle: write_data_array=1 and word_sel=rcv_cnt, combinationally in the same cycle. rcv_cnt then increments.
  - memory_data_valid outside FILL is ignored.
- FILL to DONE: on the cycle the 8th word is received (rcv_cnt=7 with valid).
- DONE: write_tag_array=1 for exactly one cycle, fsm_busy still 1. Next state is IDLE.
- fsm_busy=1 in FILL and DONE. Total fill latency from detection to IDLE is 1+7+MEM_LAT+1 = 13 cycles nominal.
- Counter widths: $clog2(WORDS). Wrap from 7 to 0 is not used to re-issue; issue stops at 8 requests.
- miss_detected asserted while busy is ignored. The cache re-presents the access after fsm_busy falls.
- Reset mid-fill: immediate return to IDLE with no strobes. Memory responses still in flight are dropped (state≠FILL). The tag is never written, so the set remains invalid or stale-safe.
- Memory returns data in request order; no reordering support.

Optional Feature:
CACHE_FILL_CRITICAL_WORD_FIRST_EN
- Defined:
  - Requests start at the miss word (miss_address[3:1]) and wrap modulo 8.
  - word_sel follows the same rotated order.
  - Output crit_word_valid (1 bit) pulses with the first returned word so the pipeline can restart early; fsm_busy behaviour is unchanged.
- Undefined: requests go in order 0..7 from word 0, and the crit_word_valid port is absent.

Decomposition:
- Package cache_pkg:
  - widths ADDR_W, INDEX_W, TAG_W=5, OFFSET_W=4, WORDS.
  - enum fill_state_t {IDLE, FILL, DONE}.
  - field-extract functions get_tag, get_index, get_word.
- Sub-module: fill_counter (parameterised up-counter with enable, clear, terminal-count), instantiated twice for the issue and receive sides.

Test Plan:
- Reset with rst_n=0 asserted mid-cycle → all outputs 0 asynchronously, state IDLE.
- Miss at 16'h1A36 → set_index=7'h23; addresses 16'h1A30,32,...,3E on 8 consecutive cycles; 8 write_data_array pulses with word_sel 0..7; one write_tag_array after the last; fsm_busy high 13 cycles.
- memory_data_valid with gaps (valid, idle, valid...) → rcv_cnt advances only on valid; DONE only after the 8th valid; tag strobe count=1.
- miss_detected held high throughout a fill, then a new miss at 16'hFFF0 → second fill starts only after IDLE, set_index=7'h7F.
- rst_n pulsed low after 3 words received → no write_tag_array; late valids are ignored; next miss does a clean full fill.
- With CACHE_FILL_CRITICAL_WORD_FIRST_EN, miss at 16'h004A → request order words 5,6,7,0,...,4 (16'h004A,4C,4E,40,...); crit_word_valid coincides with word_sel=5.
